// File: rtl/sm3_compress_iter.sv
// Iterative SM3 compression engine: RPC rounds per clock, start/done handshake.
// Optional `SM3_CHAIN_EN adds a chain input that reuses the previous v_out as the chaining value.
//
// state | meaning
// IDLE  | waiting for start; in_ready=1
// RUN   | applying RPC rounds per edge; busy=1
module sm3_compress_iter #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef SM3_CHAIN_EN
  input  logic         chain,
`endif
  input  logic [511:0] block_in,
  input  logic [255:0] v_in,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] v_out
);

  localparam int CYC = 64 / RPC;
  localparam logic [6:0] RPC7 = 7'(RPC);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sm3_compress_iter: RPC must be 1, 2, 4 or 8");
  end

  logic [0:0]   state;
  logic [6:0]   j;
  logic [31:0]  w [0:15];
  logic [255:0] vr;
  logic [255:0] v_save;
  logic [255:0] v_sel;

  logic [31:0]  ext [0:15+RPC];
  logic [255:0] st  [0:RPC];

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
  endfunction

  function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] wj,
                                               input logic [31:0] wj4, input logic [6:0] jj);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t, a12, ss1, ss2, ff, gg, tt1, tt2;
    {a, b, c, d, e, f, g, h} = s;
    t   = (jj < 7'd16) ? 32'h79cc4519 : 32'h7a879d8a;
    a12 = rol(a, 5'd12);
    ss1 = rol(a12 + e + rol(t, jj[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    if (jj < 7'd16) begin
      ff = a ^ b ^ c;
      gg = e ^ f ^ g;
    end else begin
      ff = (a & b) | (a & c) | (b & c);
      gg = (e & f) | (~e & g);
    end
    tt1 = ff + d + ss2 + (wj ^ wj4);
    tt2 = gg + h + ss1 + wj;
    return {tt1, a, rol(b, 5'd9), c, p0(tt2), e, rol(f, 5'd19), g};
  endfunction

  // Extended window: current 16 words followed by the RPC words expanded this cycle.
  always_comb begin
    for (int k = 0; k < 16; k++) ext[k] = w[k];
    for (int k = 0; k < RPC; k++) begin
      ext[16+k] = p1(ext[k] ^ ext[k+7] ^ rol(ext[k+13], 5'd15))
                  ^ rol(ext[k+3], 5'd7) ^ ext[k+10];
    end
    st[0] = vr;
    for (int k = 0; k < RPC; k++) begin
      st[k+1] = round_step(st[k], ext[k], ext[k+4], j + 7'(k));
    end
  end

`ifdef SM3_CHAIN_EN
  assign v_sel = chain ? v_out : v_in;
`else
  assign v_sel = v_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      j      <= '0;
      vr     <= '0;
      v_save <= '0;
      v_out  <= '0;
      done   <= 1'b0;
      for (int k = 0; k < 16; k++) w[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            j      <= '0;
            vr     <= v_sel;
            v_save <= v_sel;
            for (int k = 0; k < 16; k++) w[k] <= block_in[511-32*k -: 32];
          end
        end
        default: begin
          vr <= st[RPC];
          j  <= j + RPC7;
          for (int k = 0; k < 16; k++) w[k] <= ext[k+RPC];
          if (j + RPC7 == 7'd64) begin
            state <= IDLE;
            v_out <= v_save ^ st[RPC];
            done  <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);

endmodule

// File: tb/tb_sm3_compress_iter.sv
// Directed bench for sm3_compress_iter: four instances (RPC=1,2,4,8) against known SM3 digests.
module tb_sm3_compress_iter;

  localparam logic [255:0] IV      = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] DIG_ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [511:0] BLK_A4  = {16{32'h61626364}};
  localparam logic [511:0] BLK_PAD = {32'h80000000, {14{32'h0}}, 32'h00000200};
  localparam logic [255:0] DIG_A4  = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   start_v;
  logic [3:0]   chain_v;
  logic [511:0] block_in;
  logic [255:0] v_in;
  logic [3:0]   ready_v, busy_v, done_v;
  logic [255:0] vout_v [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sm3_compress_iter #(.RPC(1 << g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_v[g]),
`ifdef SM3_CHAIN_EN
      .chain   (chain_v[g]),
`endif
      .block_in(block_in),
      .v_in    (v_in),
      .in_ready(ready_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .v_out   (vout_v[g])
    );
  end

  // Called at the first negedge after the accept edge; n = edges until done is seen.
  task automatic wait_done(input int idx, input int budget, output int n, output int bc, output bit ok);
    n = 0; bc = 0; ok = 0;
    while (n < budget) begin
      if (done_v[idx]) begin
        ok = 1;
        break;
      end
      if (busy_v[idx]) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_start(input int idx, input logic [511:0] blk, input logic [255:0] v);
    @(negedge clk);
    block_in = blk; v_in = v; start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ready_v[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", i, ready_v[i]); end
      checks++; if (busy_v[i] !== 1'b0)  begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy_v[i]); end
      checks++; if (done_v[i] !== 1'b0)  begin errors++; $display("FAIL reset_done[%0d] got %b want 0", i, done_v[i]); end
      checks++; if (vout_v[i] !== 256'h0) begin errors++; $display("FAIL reset_v_out[%0d] got %h want 0", i, vout_v[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_abc;
    int n, bc; bit ok;
    for (int i = 0; i < 4; i++) begin
      pulse_start(i, BLK_ABC, IV);
      wait_done(i, 100, n, bc, ok);
      checks++; if (!ok || n != (64 >> i)) begin errors++; $display("FAIL abc_latency[%0d] got %0d (seen=%0b) want %0d", i, n, ok, 64 >> i); end
      checks++; if (bc != (64 >> i)) begin errors++; $display("FAIL abc_busy_cycles[%0d] got %0d want %0d", i, bc, 64 >> i); end
      checks++; if (vout_v[i] !== DIG_ABC) begin errors++; $display("FAIL abc_digest[%0d] got %h want %h", i, vout_v[i], DIG_ABC); end
      checks++; if (ready_v[i] !== 1'b1) begin errors++; $display("FAIL abc_ready_on_done[%0d] got %b want 1", i, ready_v[i]); end
      @(negedge clk);
      checks++; if (done_v[i] !== 1'b0) begin errors++; $display("FAIL abc_done_width[%0d] got %b want 0", i, done_v[i]); end
      checks++; if (vout_v[i] !== DIG_ABC) begin errors++; $display("FAIL abc_hold[%0d] got %h want %h", i, vout_v[i], DIG_ABC); end
    end
  endtask

  task automatic test_back_to_back;
    int n, bc; bit ok;
    for (int i = 0; i < 4; i++) begin
      pulse_start(i, BLK_A4, IV);
      wait_done(i, 100, n, bc, ok);
      checks++; if (!ok || n != (64 >> i)) begin errors++; $display("FAIL b2b_first_latency[%0d] got %0d want %0d", i, n, 64 >> i); end
      checks++; if (ready_v[i] !== 1'b1) begin errors++; $display("FAIL b2b_ready_on_done[%0d] got %b want 1", i, ready_v[i]); end
      block_in = BLK_PAD;
`ifdef SM3_CHAIN_EN
      v_in = 256'h0;
      chain_v[i] = 1'b1;
`else
      v_in = vout_v[i];
`endif
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0; chain_v[i] = 1'b0; v_in = 256'h0;
      checks++; if (busy_v[i] !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble[%0d] busy got %b want 1", i, busy_v[i]); end
      wait_done(i, 100, n, bc, ok);
      checks++; if (!ok || n != (64 >> i)) begin errors++; $display("FAIL b2b_second_latency[%0d] got %0d want %0d", i, n, 64 >> i); end
      checks++; if (vout_v[i] !== DIG_A4) begin errors++; $display("FAIL b2b_digest[%0d] got %h want %h", i, vout_v[i], DIG_A4); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_busy;
    int n, bc, dones; bit ok;
    pulse_start(0, BLK_ABC, IV);
    repeat (4) @(negedge clk);
    block_in = ~BLK_ABC; v_in = ~IV; start_v[0] = 1'b1;
    checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("FAIL ignore_ready_in_run got %b want 0", ready_v[0]); end
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 100, n, bc, ok);
    checks++; if (!ok || n != 57) begin errors++; $display("FAIL ignore_latency got %0d want 57", n); end
    checks++; if (vout_v[0] !== DIG_ABC) begin errors++; $display("FAIL ignore_digest got %h want %h", vout_v[0], DIG_ABC); end
    dones = 0;
    repeat (70) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL ignore_extra_done got %0d want 0", dones); end
    block_in = BLK_ABC; v_in = IV;
  endtask

  task automatic test_reset_abort;
    int n, bc, dones; bit ok;
    pulse_start(0, BLK_ABC, IV);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", ready_v[0]); end
    checks++; if (busy_v[0] !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b want 0", busy_v[0]); end
    checks++; if (vout_v[0] !== 256'h0) begin errors++; $display("FAIL abort_v_out got %h want 0", vout_v[0]); end
    checks++; if (vout_v[3] !== 256'h0) begin errors++; $display("FAIL abort_v_out_rpc8 got %h want 0", vout_v[3]); end
    dones = 0;
    repeat (80) begin
      if (done_v[0]) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_done got %0d want 0", dones); end
    pulse_start(0, BLK_ABC, IV);
    wait_done(0, 100, n, bc, ok);
    checks++; if (!ok || n != 64) begin errors++; $display("FAIL abort_rerun_latency got %0d want 64", n); end
    checks++; if (vout_v[0] !== DIG_ABC) begin errors++; $display("FAIL abort_rerun_digest got %h want %h", vout_v[0], DIG_ABC); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_v = '0; chain_v = '0; block_in = '0; v_in = '0;
    test_reset();
    test_abc();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm3_compress_iter.md
Name: sm3_compress_iter

Overview:
- Iterative SM3 compression function engine.
- Takes one 512-bit padded message block and a 256-bit chaining value, runs all 64 rounds with on-the-fly message expansion, and returns V(i+1) = V(i) XOR state64.
- Sits between the padding/block-feed logic and the hash output register.
- Generalises the single-round combinational step: it unrolls a configurable number of rounds per clock and adds a start/done handshake.

Parameters:
- RPC, 1, rounds evaluated per clock. Legal values are 1, 2, 4, 8. Any other value must trigger an elaboration-time error.
- CYC, 64/RPC, derived (localparam). Number of RUN cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to compress one block. Sampled only when in_ready=1.
- block_in  input  512  message block. [511:480]=W0, [31:0]=W15, each word big-endian.
- v_in  input  256  chaining value. [255:224]=A ... [31:0]=H.
- in_ready  output  1  high in IDLE; start is accepted at that edge.
- busy  output  1  high while rounds are executing.
- done  output  1  one-cycle pulse; v_out is valid from this cycle onward.
- v_out  output  256  compressed result, same packing as v_in. Held until the next done.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, round counter=0, W window=0, working regs=0.
  - in_ready=1, busy=0, done=0, v_out=0.
  - Reset during RUN aborts the block; no done is produced.
- FSM, two states:
  - IDLE -> RUN on start&in_ready. At that edge: load the 16-word W window from block_in, load A..H from v_in, save v_in to v_save, clear counter j to 0.
  - RUN: each edge applies RPC rounds j..j+RPC-1, shifts the W window by RPC words, and sets j += RPC.
  - RUN -> IDLE on the edge where j+RPC==64. At that edge: v_out <= v_save ^ {A..H after round 63}, done <= 1.
- Round function, for round j:
  - T = 79cc4519 for j<=15, else 7a879d8a. Rotate left by j mod 32.
  - SS1 = ROL7(ROL12(A)+E+ROL(T)).
  - SS2 = SS1^ROL12(A).
  - FF and GG are the XOR form for j<=15, majority / choose form otherwise.
  - TT1 = FF+D+SS2+W'j.
  - TT2 = GG+H+SS1+Wj.
  - Next state: A=TT1, B=A, C=ROL9(B), D=C, E=P0(TT2), F=E, G=ROL19(F), H=G.
  - All additions are mod 2^32.
  - Within one cycle, the RPC rounds chain combinationally, each using its own j.
- Message expansion:
  - Window holds W[j..j+15].
  - W' j = W[j]^W[j+4].
  - New word W[j+16] = P1(W[j]^W[j+7]^ROL15(W[j+13]))^ROL7(W[j+3])^W[j+10].
  - P0(x) = x^ROL9(x)^ROL17(x). P1(x) = x^ROL15(x)^ROL23(x).
  - RPC new words are generated per cycle. Expansion never needs words beyond W67.
- Latency:
  - start is accepted at edge E0. done is high in the cycle following edge E0+CYC.
  - in_ready rises in the same cycle as done, so back-to-back blocks start with zero bubble. Throughput is one block per CYC cycles.
- Output timing:
  - busy = (state==RUN).
  - in_ready = (state==IDLE).
  - done is registered and lasts exactly one cycle.
- Boundary conditions:
  - start while busy is ignored; the current block is not disturbed.
  - block_in and v_in are only sampled at the accept edge. Later changes have no effect.
  - Counter wrap: j never exceeds 64 and returns to 0 only on a new accept.

Optional Feature:
- SM3_CHAIN_EN
  - Defined: adds input port chain (1 bit), sampled with start. When chain=1, the previous v_out is used as the chaining value and v_in is ignored. This lets multi-block messages run without the host feeding back v_out.
  - Undefined: the chain port is absent and v_in is always used.
  - Either way, chain=0 behaviour is identical to the undefined build.

Test Plan:
1. "abc" block (W0=61626380, W1..W14=0, W15=00000018), v_in=IV 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e -> v_out=66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
2. RPC=1/2/4/8, same block -> identical v_out. done arrives exactly 64/32/16/8 cycles after the accept edge; busy stays high for exactly CYC cycles.
3. 64-byte "abcd"x16, two blocks back-to-back: second block fed with v_in = first v_out, start held high on the done cycle (with SM3_CHAIN_EN: chain=1) -> final v_out=debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732. No idle cycle between the two blocks.
4. Start pulse plus changed block_in/v_in at cycle 5 of RUN -> ignored. Test-1 result is unchanged and only one done pulse occurs.
5. rst_n=0 for one cycle at RUN cycle 10 -> next cycle in_ready=1, busy=0, v_out=0, no done. A subsequent test-1 run still yields the correct digest.
